// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline-to-hazard-unit signal bundle.
// Ports/modports: master = pipeline side (drives stage fields, receives forward/stall/flush),
// slave = hazard unit side (receives stage fields, drives forward/stall/flush/outstanding).
interface hazard_scoreboard_unit_if #(
  parameter int REG_W = 5,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [REG_W-1:0] rs1_D, rs2_D, rd_D;
  logic uses_rs1_D, uses_rs2_D, RegWrite_D, long_D;
  logic [REG_W-1:0] rs1_E, rs2_E, rd_E;
  logic RegWrite_E, MemRead_E, long_E, PCSrc_E;
  logic RegWrite_M, RegWrite_W, long_done;
  logic [REG_W-1:0] rd_M, rd_W, long_rd;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic stall_F, stall_D, flush_D, flush_E;
  logic [OW-1:0] outstanding;
  modport master (
    output rs1_D, rs2_D, rd_D, uses_rs1_D, uses_rs2_D, RegWrite_D, long_D,
    output rs1_E, rs2_E, rd_E, RegWrite_E, MemRead_E, long_E, PCSrc_E,
    output RegWrite_M, rd_M, RegWrite_W, rd_W, long_done, long_rd,
    input ForwardA_E, ForwardB_E, stall_F, stall_D, flush_D, flush_E, outstanding
  );
  modport slave (
    input rs1_D, rs2_D, rd_D, uses_rs1_D, uses_rs2_D, RegWrite_D, long_D,
    input rs1_E, rs2_E, rd_E, RegWrite_E, MemRead_E, long_E, PCSrc_E,
    input RegWrite_M, rd_M, RegWrite_W, rd_W, long_done, long_rd,
    output ForwardA_E, ForwardB_E, stall_F, stall_D, flush_D, flush_E, outstanding
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: RV32I forwarding, load/long-use stall, branch flush and mul/div scoreboard.
// Ports: clk, rst_n (async active-low), bus (hazard_scoreboard_unit_if.slave).
// Optional HAZARD_PERF_EN adds stall_cycles/flush_cycles saturating 32-bit counters.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_unit_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [NUM_REGS-1:0] pending, pending_n;
  logic [OW-1:0] count;
  logic set, clr, lu_stall, sb_stall, cap_stall, stall;
  assign bus.ForwardA_E = (bus.RegWrite_M && bus.rd_M != '0 && bus.rd_M == bus.rs1_E) ? 2'b10 :
                          (bus.RegWrite_W && bus.rd_W != '0 && bus.rd_W == bus.rs1_E) ? 2'b01 : 2'b00;
  assign bus.ForwardB_E = (bus.RegWrite_M && bus.rd_M != '0 && bus.rd_M == bus.rs2_E) ? 2'b10 :
                          (bus.RegWrite_W && bus.rd_W != '0 && bus.rd_W == bus.rs2_E) ? 2'b01 : 2'b00;
  assign lu_stall = (bus.MemRead_E || bus.long_E) && bus.RegWrite_E && bus.rd_E != '0 &&
                    ((bus.uses_rs1_D && bus.rs1_D == bus.rd_E) || (bus.uses_rs2_D && bus.rs2_D == bus.rd_E));
  // Registered pending bits only: a result completing this cycle releases the stall next cycle.
  assign sb_stall = (bus.uses_rs1_D && pending[bus.rs1_D]) || (bus.uses_rs2_D && pending[bus.rs2_D]) ||
                    (bus.RegWrite_D && pending[bus.rd_D]);
  assign cap_stall = bus.long_D && count == OW'(MAX_OUTSTANDING);
  assign stall = lu_stall || sb_stall || cap_stall;
  assign bus.stall_F = stall && !bus.PCSrc_E;
  assign bus.stall_D = stall && !bus.PCSrc_E;
  assign bus.flush_E = stall || bus.PCSrc_E;
  assign bus.flush_D = bus.PCSrc_E;
  assign bus.outstanding = count;
  always_comb begin
    set = bus.long_E && bus.RegWrite_E && bus.rd_E != '0;
    clr = bus.long_done && bus.long_rd != '0 && pending[bus.long_rd];
    pending_n = pending;
    if (clr) pending_n[bus.long_rd] = 1'b0;
    if (set) pending_n[bus.rd_E] = 1'b1;
    pending_n[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count <= '0;
    end else begin
      pending <= pending_n;
      if (set && !clr && count != OW'(MAX_OUTSTANDING)) count <= count + 1'b1;
      else if (clr && !set && count != '0) count <= count - 1'b1;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (bus.stall_D && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (bus.flush_D && flush_cycles != '1) flush_cycles <= flush_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed stimulus with a per-cycle reference model and literal checks.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit mp[32];
  bit e_st, e_fl;
  hazard_scoreboard_unit_if #(.REG_W(5), .MAX_OUTSTANDING(4)) bus();
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
  longint m_sc = 0, m_fc = 0;
  hazard_scoreboard_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                              .stall_cycles(stall_cycles), .flush_cycles(flush_cycles));
`else
  hazard_scoreboard_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input int rs);
    if (bus.RegWrite_M && bus.rd_M != 0 && int'(bus.rd_M) == rs) return 2;
    if (bus.RegWrite_W && bus.rd_W != 0 && int'(bus.rd_W) == rs) return 1;
    return 0;
  endfunction

  // Reference scoreboard: a set of in-flight destination registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mp[i]) mp[i] <= 1'b0;
`ifdef HAZARD_PERF_EN
      m_sc <= 0;
      m_fc <= 0;
`endif
    end else begin
      if (bus.long_done && bus.long_rd != 0) mp[bus.long_rd] <= 1'b0;
      if (bus.long_E && bus.RegWrite_E && bus.rd_E != 0) mp[bus.rd_E] <= 1'b1;
`ifdef HAZARD_PERF_EN
      if (e_st && m_sc < 64'hFFFF_FFFF) m_sc <= m_sc + 1;
      if (e_fl && m_fc < 64'hFFFF_FFFF) m_fc <= m_fc + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int cnt;
      bit lu, sb, cap, st;
      cnt = 0;
      foreach (mp[i]) cnt += int'(mp[i]);
      lu = (bus.MemRead_E || bus.long_E) && bus.RegWrite_E && bus.rd_E != 0 &&
           ((bus.uses_rs1_D && bus.rs1_D == bus.rd_E) || (bus.uses_rs2_D && bus.rs2_D == bus.rd_E));
      sb = (bus.uses_rs1_D && mp[bus.rs1_D]) || (bus.uses_rs2_D && mp[bus.rs2_D]) ||
           (bus.RegWrite_D && mp[bus.rd_D]);
      cap = bus.long_D && cnt == 4;
      st = lu || sb || cap;
      e_st = st && !bus.PCSrc_E;
      e_fl = bus.PCSrc_E;
      chk("m_fwdA", 32'(bus.ForwardA_E), 32'(exp_fwd(int'(bus.rs1_E))));
      chk("m_fwdB", 32'(bus.ForwardB_E), 32'(exp_fwd(int'(bus.rs2_E))));
      chk("m_stallF", 32'(bus.stall_F), 32'(e_st));
      chk("m_stallD", 32'(bus.stall_D), 32'(e_st));
      chk("m_flushE", 32'(bus.flush_E), 32'(st || bus.PCSrc_E));
      chk("m_flushD", 32'(bus.flush_D), 32'(bus.PCSrc_E));
      chk("m_outst", 32'(bus.outstanding), 32'(cnt));
`ifdef HAZARD_PERF_EN
      chk("m_scyc", stall_cycles, 32'(m_sc));
      chk("m_fcyc", flush_cycles, 32'(m_fc));
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {bus.rs1_D, bus.rs2_D, bus.rd_D, bus.rs1_E, bus.rs2_E, bus.rd_E} = '0;
    {bus.uses_rs1_D, bus.uses_rs2_D, bus.RegWrite_D, bus.long_D} = '0;
    {bus.RegWrite_E, bus.MemRead_E, bus.long_E, bus.PCSrc_E} = '0;
    {bus.RegWrite_M, bus.rd_M, bus.RegWrite_W, bus.rd_W, bus.long_done, bus.long_rd} = '0;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.long_E = 1'b1;
    bus.RegWrite_E = 1'b1;
    bus.rd_E = r;
  endtask

  initial begin
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outst", 32'(bus.outstanding), 0);
    chk("rst_stallD", 32'(bus.stall_D), 0);
    chk("rst_flushE", 32'(bus.flush_E), 0);
    chk("rst_fwdA", 32'(bus.ForwardA_E), 0);
    tick();
    // forwarding priority
    bus.RegWrite_M = 1'b1; bus.rd_M = 5; bus.RegWrite_W = 1'b1; bus.rd_W = 5; bus.rs1_E = 5; bus.rs2_E = 5;
    @(negedge clk);
    chk("fwd_M", 32'(bus.ForwardA_E), 2);
    bus.RegWrite_M = 1'b0;
    #1 chk("fwd_W", 32'(bus.ForwardA_E), 1);
    bus.RegWrite_M = 1'b1; bus.rd_M = 0; bus.rd_W = 0;
    #1 chk("fwd_x0", 32'(bus.ForwardB_E), 0);
    tick();
    // load-use for one cycle
    idle();
    bus.MemRead_E = 1'b1; bus.RegWrite_E = 1'b1; bus.rd_E = 7; bus.uses_rs2_D = 1'b1; bus.rs2_D = 7;
    @(negedge clk);
    chk("lu_stallF", 32'(bus.stall_F), 1);
    chk("lu_stallD", 32'(bus.stall_D), 1);
    chk("lu_flushE", 32'(bus.flush_E), 1);
    tick();
    bus.MemRead_E = 1'b0; bus.RegWrite_E = 1'b0;
    @(negedge clk);
    chk("lu_release", 32'(bus.stall_D), 0);
    tick();
    // long op to x9, consumer in D, completion at cycle 5
    idle();
    issue(9);
    tick();
    idle();
    bus.uses_rs1_D = 1'b1; bus.rs1_D = 9;
    for (int c = 1; c <= 6; c++) begin
      bus.long_done = (c == 5);
      bus.long_rd = (c == 5) ? 5'd9 : 5'd0;
      @(negedge clk);
      chk($sformatf("sb_stall_c%0d", c), 32'(bus.stall_D), 32'(c <= 5));
      chk($sformatf("sb_outst_c%0d", c), 32'(bus.outstanding), 32'(c <= 5));
      tick();
    end
    // outstanding cap
    for (int i = 1; i <= 4; i++) begin
      idle();
      issue(5'(i));
      tick();
    end
    idle();
    bus.long_D = 1'b1;
    @(negedge clk);
    chk("cap_outst", 32'(bus.outstanding), 4);
    chk("cap_stall", 32'(bus.stall_D), 1);
    tick();
    bus.long_done = 1'b1; bus.long_rd = 1;
    @(negedge clk);
    chk("cap_hold", 32'(bus.stall_D), 1);
    tick();
    bus.long_done = 1'b0; bus.long_rd = 0;
    @(negedge clk);
    chk("cap_release", 32'(bus.stall_D), 0);
    chk("cap_outst3", 32'(bus.outstanding), 3);
    tick();
    // branch beats stall
    idle();
    bus.MemRead_E = 1'b1; bus.RegWrite_E = 1'b1; bus.rd_E = 7; bus.uses_rs1_D = 1'b1; bus.rs1_D = 7; bus.PCSrc_E = 1'b1;
    @(negedge clk);
    chk("br_flushD", 32'(bus.flush_D), 1);
    chk("br_flushE", 32'(bus.flush_E), 1);
    chk("br_stallF", 32'(bus.stall_F), 0);
    chk("br_stallD", 32'(bus.stall_D), 0);
    tick();
    // async reset mid-stall with x2..x4 pending
    idle();
    bus.uses_rs1_D = 1'b1; bus.rs1_D = 2;
    @(negedge clk);
    chk("pre_rst_stall", 32'(bus.stall_D), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_outst", 32'(bus.outstanding), 0);
    chk("arst_stallD", 32'(bus.stall_D), 0);
    chk("arst_flushE", 32'(bus.flush_E), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(bus.stall_D), 0);
    tick();
    // same-cycle set and clear on x12, WAW, x0 and stray completion
    idle();
    issue(12);
    tick();
    issue(12);
    bus.long_done = 1'b1; bus.long_rd = 12;
    tick();
    idle();
    bus.uses_rs1_D = 1'b1; bus.rs1_D = 12;
    @(negedge clk);
    chk("sc_pending", 32'(bus.stall_D), 1);
    chk("sc_outst", 32'(bus.outstanding), 1);
    tick();
    idle();
    bus.RegWrite_D = 1'b1; bus.rd_D = 12;
    @(negedge clk);
    chk("waw_stall", 32'(bus.stall_D), 1);
    tick();
    idle();
    issue(0);
    bus.long_done = 1'b1; bus.long_rd = 20;
    tick();
    idle();
    @(negedge clk);
    chk("x0_stray_outst", 32'(bus.outstanding), 1);
    tick();
    bus.long_done = 1'b1; bus.long_rd = 12;
    tick();
    idle();
    @(negedge clk);
    chk("final_outst", 32'(bus.outstanding), 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
